processor_mc: RTL and testbench

Second-generation multi-cycle RV32I core. It keeps the same single-port memory interface and the FETCH/EXECUTE/LOAD/STORE flow, and adds:
- asynchronous reset
- a parametrised reset vector
- optional RV32E register file (16 registers)
- memory wait-state handshakes (mem_rbusy/mem_wbusy)
- a sticky trap on illegal, misaligned and environment instructions

It sits between the SoC memory/bus adapter and nothing else; it is the only bus master.

---
 rtl/processor_pkg.sv | 71 +++++++
 rtl/processor_regfile.sv | 33 +++
 rtl/processor_mc.sv | 197 +++++++++++++++++++
 tb/tb_processor_mc.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared encodings for the multi-cycle RV32I/RV32E core: opcodes, funct3 values,
// controller states and the small ALU / branch-compare helpers.
package processor_pkg;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT_INSTR,
        S_EXECUTE,
        S_LOAD,
        S_STORE,
        S_WAIT_DATA,
        S_TRAP
    } state_t;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, input logic sub,
                                        input logic arith);
        case (f3)
            F3_ADD:  return sub ? a - b : a + b;
            F3_SLL:  return a << b[4:0];
            F3_SLT:  return {31'b0, $signed(a) < $signed(b)};
            F3_SLTU: return {31'b0, a < b};
            F3_XOR:  return a ^ b;
            F3_SR:   return arith ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            F3_OR:   return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        case (f3)
            F3_BEQ:  return a == b;
            F3_BNE:  return a != b;
            F3_BLT:  return $signed(a) < $signed(b);
            F3_BGE:  return $signed(a) >= $signed(b);
            F3_BLTU: return a < b;
            F3_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/processor_regfile.sv
// Register file: 16 (RV32E) or 32 (RV32I) entries, two asynchronous read ports,
// one synchronous write port, x0 hardwired to zero.
module processor_regfile #(
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [$clog2(NREGS)-1:0] raddr1,
    input  logic [$clog2(NREGS)-1:0] raddr2,
    output logic [31:0]              rdata1,
    output logic [31:0]              rdata2
);
    if (NREGS != 16 && NREGS != 32) begin : g_bad_nregs
        $error("processor_regfile: NREGS must be 16 or 32");
    end

    logic [31:0] regs [0:NREGS-1];

    // NOTE: storage arrays carry no reset so they map onto RAM/flop arrays without
    // a reset tree; x0 is forced to zero on the read side instead.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every flop samples
        // pre-edge values regardless of statement order.
        if (we && waddr != '0)
            regs[waddr] <= wdata;
    end

    assign rdata1 = (raddr1 == '0) ? 32'b0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? 32'b0 : regs[raddr2];

endmodule

// File: rtl/processor_mc.sv
// Multi-cycle RV32I/RV32E core on a single-port memory bus with wait states and
// a sticky halt-on-trap.
module processor_mc
    import processor_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          NREGS         = 32,
    parameter bit          TRAP_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        mem_rstrb,
    input  logic        mem_rbusy,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_wbusy,
    output logic        trap
);
    localparam int RAW = $clog2(NREGS);

    state_t      state, next_state;
    logic [31:0] pc, instr, rs1_q, rs2_q;
    logic [31:0] rf_rd1, rf_rd2, rf_wdata;
    logic        rf_we;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1a, rs2a;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        is_load, is_store;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign f3       = instr[14:12];
    assign rs1a     = instr[19:15];
    assign rs2a     = instr[24:20];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u    = {instr[31:12], 12'b0};
    assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);

    // Source registers are read straight off the incoming instruction word.
    processor_regfile #(.NREGS(NREGS)) u_regfile (
        .clk    (clk),
        .we     (rf_we),
        .waddr  (rd[RAW-1:0]),
        .wdata  (rf_wdata),
        .raddr1 (mem_rdata[15 +: RAW]),
        .raddr2 (mem_rdata[20 +: RAW]),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

    logic [31:0] ls_addr, alu_res, target_raw, target, next_pc, exec_wb;
    logic [31:0] load_shift, load_data;
    logic [1:0]  lane_off;
    logic [3:0]  store_mask;
    logic        ls_misaligned, trap_cond, wb_en, jump;
    logic        uses_rd, uses_rs1, uses_rs2;

    assign ls_addr       = rs1_q + (is_store ? imm_s : imm_i);
    assign alu_res       = alu(f3, rs1_q, (opcode == OPC_OP) ? rs2_q : imm_i,
                               (opcode == OPC_OP) && instr[30], instr[30]);
    assign ls_misaligned = (f3[1:0] == 2'b01 && ls_addr[0]) ||
                           (f3[1:0] == 2'b10 && ls_addr[1:0] != 2'b00);
    assign target        = TRAP_MISALIGN ? target_raw : {target_raw[31:2], 2'b00};
    assign next_pc       = jump ? target : pc + 32'd4;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        trap_cond  = 1'b0;
        wb_en      = 1'b0;
        jump       = 1'b0;
        uses_rd    = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        exec_wb    = alu_res;
        target_raw = pc + imm_b;
        case (opcode)
            OPC_OP:       begin wb_en = 1'b1; uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_OP_IMM:   begin wb_en = 1'b1; uses_rd = 1'b1; uses_rs1 = 1'b1; end
            OPC_LUI:      begin wb_en = 1'b1; uses_rd = 1'b1; exec_wb = imm_u; end
            OPC_AUIPC:    begin wb_en = 1'b1; uses_rd = 1'b1; exec_wb = pc + imm_u; end
            OPC_JAL: begin
                wb_en = 1'b1; uses_rd = 1'b1; jump = 1'b1;
                exec_wb = pc + 32'd4; target_raw = pc + imm_j;
            end
            OPC_JALR: begin
                wb_en = 1'b1; uses_rd = 1'b1; uses_rs1 = 1'b1; jump = 1'b1;
                exec_wb = pc + 32'd4; target_raw = (rs1_q + imm_i) & ~32'd1;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                trap_cond = (f3[2:1] == 2'b01);
                jump = branch_taken(f3, rs1_q, rs2_q);
            end
            OPC_LOAD: begin
                uses_rd = 1'b1; uses_rs1 = 1'b1;
                trap_cond = (f3 == 3'd3) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                trap_cond = f3[2] || (f3 == 3'd3);
            end
            OPC_MISC_MEM: ;
            OPC_SYSTEM:   trap_cond = 1'b1;
            default:      trap_cond = 1'b1;
        endcase
        if (NREGS == 16 && ((uses_rd && rd[4]) || (uses_rs1 && rs1a[4]) || (uses_rs2 && rs2a[4])))
            trap_cond = 1'b1;
        if (TRAP_MISALIGN && ((jump && target_raw[1]) || ((is_load || is_store) && ls_misaligned)))
            trap_cond = 1'b1;
    end

    // Lane offset is forced to the access size so TRAP_MISALIGN=0 ignores low bits.
    always_comb begin
        case (f3[1:0])
            2'b00:   begin lane_off = ls_addr[1:0];         store_mask = 4'b0001 << lane_off; end
            2'b01:   begin lane_off = {ls_addr[1], 1'b0};   store_mask = 4'b0011 << lane_off; end
            default: begin lane_off = 2'b00;                store_mask = 4'b1111; end
        endcase
    end

    assign load_shift = mem_rdata >> {lane_off, 3'b000};
    always_comb begin
        case (f3)
            3'b000:  load_data = {{24{load_shift[7]}}, load_shift[7:0]};
            3'b001:  load_data = {{16{load_shift[15]}}, load_shift[15:0]};
            3'b100:  load_data = {24'b0, load_shift[7:0]};
            3'b101:  load_data = {16'b0, load_shift[15:0]};
            default: load_data = load_shift;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= next_state;
            if (state == S_EXECUTE && !trap_cond)
                pc <= next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_WAIT_INSTR && !mem_rbusy) begin
            instr <= mem_rdata;
            rs1_q <= rf_rd1;
            rs2_q <= rf_rd2;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:      next_state = S_WAIT_INSTR;
            S_WAIT_INSTR: if (!mem_rbusy) next_state = S_EXECUTE;
            S_EXECUTE: begin
                if (trap_cond)     next_state = S_TRAP;
                else if (is_load)  next_state = S_LOAD;
                else if (is_store) next_state = S_STORE;
                else               next_state = S_FETCH;
            end
            S_LOAD, S_STORE: next_state = S_WAIT_DATA;
            S_WAIT_DATA: if (!(is_store ? mem_wbusy : mem_rbusy)) next_state = S_FETCH;
            default:     next_state = S_TRAP;
        endcase
    end

    always_comb begin
        mem_rstrb = !reset && (state == S_FETCH || state == S_LOAD);
        mem_wmask = (state == S_STORE) ? store_mask : 4'b0000;
        mem_addr  = (state == S_FETCH || state == S_WAIT_INSTR) ? pc : ls_addr;
        trap      = (state == S_TRAP);
        case (f3[1:0])
            2'b00:   mem_wdata = {4{rs2_q[7:0]}};
            2'b01:   mem_wdata = {2{rs2_q[15:0]}};
            default: mem_wdata = rs2_q;
        endcase
        rf_we    = 1'b0;
        rf_wdata = exec_wb;
        if (state == S_EXECUTE && !trap_cond && wb_en) begin
            rf_we = 1'b1;
        end else if (state == S_WAIT_DATA && is_load && !mem_rbusy) begin
            rf_we    = 1'b1;
            rf_wdata = load_data;
        end
    end

endmodule

// File: tb/tb_processor_mc.sv
// Bus-level scoreboard bench for processor_mc: expected fetch/load/store events are
// queued with the program and compared as the core drives the memory bus.
module tb_processor_mc;

    localparam logic [6:0] O_OPIMM = 7'b0010011;
    localparam logic [6:0] O_LOAD  = 7'b0000011;
    localparam logic [6:0] O_STORE = 7'b0100011;
    localparam logic [6:0] O_JALR  = 7'b1100111;

    typedef struct {
        bit          wr;
        bit          fetch;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        int          gap;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  last_fetch = 0;
    int  ev_n = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_addr, mem_rdata, mem_wdata;
    logic        mem_rstrb, mem_rbusy, mem_wbusy, trap;
    logic [3:0]  mem_wmask;

    logic [31:0] e_addr, e_wdata;
    logic [31:0] e_rdata = 32'b0;
    logic        e_rstrb, e_trap;
    logic [3:0]  e_wmask;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    processor_mc #(.RESET_PC(32'h100), .NREGS(32), .TRAP_MISALIGN(1'b1)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_rstrb(mem_rstrb), .mem_rbusy(mem_rbusy), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_wbusy(mem_wbusy), .trap(trap)
    );

    processor_mc #(.RESET_PC(32'h0), .NREGS(16), .TRAP_MISALIGN(1'b1)) u_e (
        .clk(clk), .reset(reset), .mem_addr(e_addr), .mem_rdata(e_rdata),
        .mem_rstrb(e_rstrb), .mem_rbusy(1'b0), .mem_wmask(e_wmask),
        .mem_wdata(e_wdata), .mem_wbusy(1'b0), .trap(e_trap)
    );

    // Main memory: 1 KiB, read data valid after the strobe, busy injected by address.
    logic [31:0] mem [0:255];
    logic [31:0] rd_addr = 32'b0;
    int          rbusy_cnt = 0;
    int          wbusy_cnt = 0;

    always @(posedge clk) begin
        if (mem_rstrb) begin
            rd_addr   <= mem_addr;
            rbusy_cnt <= (mem_addr == 32'h124) ? 4 : 0;
        end else if (rbusy_cnt != 0) begin
            rbusy_cnt <= rbusy_cnt - 1;
        end
        if (mem_wmask != 4'b0) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            wbusy_cnt <= (mem_addr == 32'h3) ? 2 : 0;
        end else if (wbusy_cnt != 0) begin
            wbusy_cnt <= wbusy_cnt - 1;
        end
    end

    assign mem_rdata = mem[rd_addr[9:2]];
    assign mem_rbusy = (rbusy_cnt != 0);
    assign mem_wbusy = (wbusy_cnt != 0);

    logic [31:0] e_rom [0:3];
    always @(posedge clk) if (e_rstrb) e_rdata <= e_rom[e_addr[3:2]];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        logic [31:0] v = imm;
        return {v[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        logic [31:0] v = imm;
        return {v[11:5], rs2[4:0], rs1[4:0], f3[2:0], v[4:0], O_STORE};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] v = imm;
        return {v[12], v[10:5], rs2[4:0], rs1[4:0], f3[2:0], v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rd[4:0], 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    task automatic push_f(input logic [31:0] addr, input int gap);
        exp_q.push_back('{wr: 1'b0, fetch: 1'b1, addr: addr, mask: 4'b0, data: 32'b0, gap: gap});
    endtask

    task automatic push_r(input logic [31:0] addr);
        exp_q.push_back('{wr: 1'b0, fetch: 1'b0, addr: addr, mask: 4'b0, data: 32'b0, gap: 0});
    endtask

    task automatic push_w(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        exp_q.push_back('{wr: 1'b1, fetch: 1'b0, addr: addr, mask: mask, data: data, gap: 0});
    endtask

    task automatic observe(input bit wr, input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] data);
        ev_t e;
        ev_n++;
        if (exp_q.size() == 0) begin
            check($sformatf("ev%0d_unexpected_bus_event_queue_size", ev_n), exp_q.size(), 1);
            return;
        end
        e = exp_q.pop_front();
        check($sformatf("ev%0d_is_write", ev_n), {31'b0, wr}, {31'b0, e.wr});
        check($sformatf("ev%0d_addr", ev_n), addr, e.addr);
        if (e.wr) begin
            check($sformatf("ev%0d_wmask", ev_n), {28'b0, mask}, {28'b0, e.mask});
            check($sformatf("ev%0d_wdata", ev_n), data, e.data);
        end
        if (e.fetch) begin
            if (e.gap != 0) check($sformatf("ev%0d_fetch_gap", ev_n), cyc - last_fetch, e.gap);
            last_fetch = cyc;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_rstrb) observe(1'b0, mem_addr, 4'b0, 32'b0);
            if (mem_wmask != 4'b0) observe(1'b1, mem_addr, mem_wmask, mem_wdata);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'b0;
        // Program at RESET_PC 0x100.
        mem[64] <= enc_i(-5, 0, 0, 1, O_OPIMM);        // addi x1,x0,-5
        mem[65] <= enc_i(0, 1, 2, 2, O_OPIMM);         // slti x2,x1,0
        mem[66] <= enc_i(32'h401, 1, 5, 3, O_OPIMM);   // srai x3,x1,1
        mem[67] <= enc_s(4, 1, 0, 2);                  // sw x1,4(x0)
        mem[68] <= enc_s(8, 2, 0, 2);                  // sw x2,8(x0)
        mem[69] <= enc_s(12, 3, 0, 2);                 // sw x3,12(x0)
        mem[70] <= enc_s(3, 1, 0, 0);                  // sb x1,3(x0)
        mem[71] <= enc_i(3, 0, 0, 4, O_LOAD);          // lb x4,3(x0)
        mem[72] <= enc_i(3, 0, 4, 5, O_LOAD);          // lbu x5,3(x0)
        mem[73] <= enc_s(16, 4, 0, 2);                 // sw x4,16(x0)
        mem[74] <= enc_s(20, 5, 0, 2);                 // sw x5,20(x0)
        mem[75] <= enc_r(0, 2, 1, 0, 6);               // add x6,x1,x2
        mem[76] <= enc_r(32, 1, 2, 0, 7);              // sub x7,x2,x1
        mem[77] <= enc_s(24, 6, 0, 2);                 // sw x6,24(x0)
        mem[78] <= enc_s(28, 7, 0, 2);                 // sw x7,28(x0)
        mem[79] <= enc_j(32'h20 - 32'h13C, 0);         // jal x0,0x20
        mem[8]  <= enc_b(8, 0, 0, 0);                  // 0x20: beq x0,x0,+8
        mem[10] <= enc_i(32'h40, 0, 0, 2, O_OPIMM);    // 0x28: addi x2,x0,0x40
        mem[11] <= enc_i(1, 2, 0, 1, O_JALR);          // 0x2C: jalr x1,x2,1
        mem[16] <= enc_s(0, 1, 0, 2);                  // 0x40: sw x1,0(x0)
        mem[17] <= enc_i(2, 0, 2, 8, O_LOAD);          // 0x44: lw x8,2(x0)
        e_rom[0] <= enc_i(3, 0, 0, 1, O_OPIMM);        // addi x1,x0,3
        e_rom[1] <= enc_r(0, 1, 1, 0, 20);             // add x20,x1,x1
        e_rom[2] <= 32'h0000_0013;
        e_rom[3] <= 32'h0000_0013;

        push_f(32'h100, 0); push_f(32'h104, 3); push_f(32'h108, 3); push_f(32'h10C, 3);
        push_w(32'h4, 4'hF, 32'hFFFF_FFFB);  push_f(32'h110, 5);
        push_w(32'h8, 4'hF, 32'h0000_0001);  push_f(32'h114, 5);
        push_w(32'hC, 4'hF, 32'hFFFF_FFFD);  push_f(32'h118, 5);
        push_w(32'h3, 4'b1000, 32'hFBFB_FBFB); push_f(32'h11C, 7);
        push_r(32'h3); push_f(32'h120, 5);
        push_r(32'h3); push_f(32'h124, 5);
        push_w(32'h10, 4'hF, 32'hFFFF_FFFB); push_f(32'h128, 9);
        push_w(32'h14, 4'hF, 32'h0000_00FB); push_f(32'h12C, 5);
        push_f(32'h130, 3); push_f(32'h134, 3);
        push_w(32'h18, 4'hF, 32'hFFFF_FFFC); push_f(32'h138, 5);
        push_w(32'h1C, 4'hF, 32'h0000_0006); push_f(32'h13C, 5);
        push_f(32'h20, 3); push_f(32'h28, 3); push_f(32'h2C, 3); push_f(32'h40, 3);
        push_w(32'h0, 4'hF, 32'h0000_0030); push_f(32'h44, 5);

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rstrb", {31'b0, mem_rstrb}, 32'd0);
        check("reset_wmask", {28'b0, mem_wmask}, 32'd0);
        check("reset_trap", {31'b0, trap}, 32'd0);
        check("reset_addr_is_reset_pc", mem_addr, 32'h100);
        reset = 1'b0;

        for (int i = 0; i < 600 && !(exp_q.size() == 0 && trap); i++) @(negedge clk);
        check("phase1_queue_drained", exp_q.size(), 0);
        check("misalign_lw_trap", {31'b0, trap}, 32'd1);
        repeat (5) @(negedge clk);
        check("trap_sticky", {31'b0, trap}, 32'd1);
        check("trap_pc_holds_fault", dut.pc, 32'h44);
        check("rv32e_trap", {31'b0, e_trap}, 32'd1);
        check("rv32e_pc_after_addi", u_e.pc, 32'h4);
        check("rv32e_no_store", {28'b0, e_wmask}, 32'd0);

        // Restart on a store and pull reset while its write pulse is on the bus.
        mem[64] <= enc_s(0, 0, 0, 2);                  // sw x0,0(x0)
        push_f(32'h100, 0);
        push_w(32'h0, 4'hF, 32'h0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 50 && mem_wmask == 4'b0; i++) @(negedge clk);
        check("store_pulse_seen", {28'b0, mem_wmask}, 32'hF);
        #1 reset = 1'b1;
        #1;
        check("wmask_async_drop", {28'b0, mem_wmask}, 32'd0);
        check("rstrb_low_in_reset", {31'b0, mem_rstrb}, 32'd0);
        mem[64] <= 32'h0000_0073;                      // ecall
        push_f(32'h100, 0);
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 50 && !trap; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("ecall_trap", {31'b0, trap}, 32'd1);
        check("ecall_pc", dut.pc, 32'h100);
        check("phase2_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
